// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, functs, state
// encodings, ALU operation codes and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_NONE
  } instr_class_t;

  function automatic logic is_rtype(input instr_class_t cls);
    return (cls == CLS_ADD) || (cls == CLS_SUB);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct onto one of the
// supported instruction classes, flagging anything else as illegal.
module mc_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic         illegal
);

  always_comb begin
    instr_class = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD) begin
          instr_class = CLS_ADD;
        end else if (funct == FN_SUB) begin
          instr_class = CLS_SUB;
        end
      end
      OP_ADDI: instr_class = CLS_ADDI;
      OP_LW:   instr_class = CLS_LW;
      OP_SW:   instr_class = CLS_SW;
      OP_BEQ:  instr_class = CLS_BEQ;
      OP_BNE:  instr_class = CLS_BNE;
      OP_J:    instr_class = CLS_J;
      default: instr_class = CLS_NONE;
    endcase
    illegal = (instr_class == CLS_NONE);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control unit: IF/ID/EX/MEM/WB sequencer with a sticky
// illegal-instruction trap and a retired-instruction counter.
module mc_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_en,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [2:0]          alu_op,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_t                state_q;
  state_t                state_d;
  logic [5:0]            opcode_q;
  logic [5:0]            funct_q;
  logic                  illegal_q;
  logic [RETIRE_W-1:0]   retire_cnt_q;
  logic                  in_id;
  logic [5:0]            dec_opcode;
  logic [5:0]            dec_funct;
  instr_class_t          cls;
  logic                  dec_illegal;

  // ID decodes the live instruction register; later states use the copy latched in ID.
  assign in_id      = (state_q == ST_ID);
  assign dec_opcode = in_id ? opcode : opcode_q;
  assign dec_funct  = in_id ? funct  : funct_q;

  mc_ctrl_decode u_decode (
    .opcode      (dec_opcode),
    .funct       (dec_funct),
    .instr_class (cls),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IF;
      opcode_q     <= '0;
      funct_q      <= '0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_id) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (state_d == ST_ERR) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = PCSRC_ALU;
    alu_op     = ALU_ADD;
    retire     = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = ST_ID;
        end
      end

      ST_ID: begin
        alu_src_b = SRCB_IMM_SH2;
        state_d   = dec_illegal ? ST_ERR : ST_EX;
      end

      ST_EX: begin
        case (cls)
          CLS_ADD, CLS_SUB: begin
            alu_src_a = 1'b1;
            alu_op    = (cls == CLS_SUB) ? ALU_SUB : ALU_ADD;
            state_d   = ST_WB;
          end
          CLS_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_source = PCSRC_ALUOUT;
            pc_en     = (cls == CLS_BEQ) ? zero : ~zero;
            retire    = 1'b1;
            state_d   = ST_IF;
          end
          CLS_J: begin
            pc_source = PCSRC_JUMP;
            pc_en     = 1'b1;
            retire    = 1'b1;
            state_d   = ST_IF;
          end
          default: state_d = ST_ERR;
        endcase
      end

      // Strobes stay asserted across wait cycles so the memory sees a stable request.
      ST_MEM: begin
        mem_read  = (cls == CLS_LW);
        mem_write = (cls == CLS_SW);
        if (mem_ready) begin
          if (cls == CLS_LW) begin
            state_d = ST_WB;
          end else if (cls == CLS_SW) begin
            retire  = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype(cls);
        mem_to_reg = (cls == CLS_LW);
        retire     = 1'b1;
        state_d    = ST_IF;
      end

      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  assign state      = state_q;
  assign illegal    = illegal_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios with literal
// expectations, then randomized traffic checked against a path-based model.
module tb_mc_control_fsm;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          ir_write, pc_en, reg_write, mem_read, mem_write;
  logic          reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic [2:0]    alu_op, state;
  logic          illegal, retire;
  logic [RW-1:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.RETIRE_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal),
    .retire     (retire),
    .retire_cnt (retire_cnt)
  );

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_BAD = 8;

  // Model: each instruction walks a list of phase numbers whose length is its latency.
  int mdl_phase = 0;
  int mdl_idx   = 0;
  int mdl_kind  = K_BAD;
  int path[5];
  int path_len  = 2;
  int mdl_cnt   = 0;
  bit mdl_illegal = 1'b0;
  bit mdl_valid   = 1'b0;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h20) ? K_ADD : ((fn == 6'h22) ? K_SUB : K_BAD);
      6'h08:   return K_ADDI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [19:0] expVec(input int ph, input int k, input bit z,
                                         input bit mr, input bit ill, input bit ret);
    bit irw = 0, pce = 0, rw = 0, mrd = 0, mwr = 0, rd = 0, m2r = 0, sa = 0;
    bit [1:0] sb = 2'b00, ps = 2'b00;
    bit [2:0] op = 3'b000;
    case (ph)
      0: begin mrd = 1; sb = 2'b01; irw = mr; pce = mr; end
      1: sb = 2'b11;
      2: begin
        if (k == K_J) begin
          ps = 2'b10; pce = 1;
        end else begin
          sa = 1;
          if (k == K_ADDI || k == K_LW || k == K_SW) sb = 2'b10;
          if (k == K_SUB || k == K_BEQ || k == K_BNE) op = 3'b001;
          if (k == K_BEQ) begin ps = 2'b01; pce = z;  end
          if (k == K_BNE) begin ps = 2'b01; pce = !z; end
        end
      end
      3: begin mrd = (k == K_LW); mwr = (k == K_SW); end
      4: begin rw = 1; rd = (k == K_ADD || k == K_SUB); m2r = (k == K_LW); end
      default: ;
    endcase
    return {irw, pce, rw, mrd, mwr, rd, m2r, sa, sb, ps, op, 3'(ph), ill, ret};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [5:0] op, input logic [5:0] fn,
                               input bit z, input bit mr);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = mr;
    @(negedge clk);
  endtask

  // Compare every cycle, then advance the model to the state expected after the next edge.
  always @(negedge clk) begin : compare_proc
    bit ret;
    if (mdl_valid) begin
      ret = (mdl_phase inside {2, 3, 4}) && (mdl_idx == path_len - 1) &&
            (mdl_phase != 3 || mem_ready);
      checkOutput("outputs",
                  32'({ir_write, pc_en, reg_write, mem_read, mem_write, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, pc_source, alu_op, state, illegal, retire}),
                  32'(expVec(mdl_phase, mdl_kind, zero, mem_ready, mdl_illegal, ret)));
      checkOutput("retire_cnt", 32'(retire_cnt), 32'(mdl_cnt));
    end
    if (rst) begin
      mdl_phase = 0; mdl_idx = 0; mdl_illegal = 0; mdl_cnt = 0; path_len = 2;
      mdl_valid = 1'b1;
    end else if (mdl_valid && mdl_phase != 7 &&
                 !((mdl_phase == 0 || mdl_phase == 3) && !mem_ready)) begin
      if (mdl_phase == 0) begin
        mdl_phase = 1; mdl_idx = 1;
      end else begin
        if (mdl_phase == 1) begin
          mdl_kind = classify(opcode, funct);
          case (mdl_kind)
            K_ADD, K_SUB, K_ADDI: begin path = '{0, 1, 2, 4, 0}; path_len = 4; end
            K_LW:                 begin path = '{0, 1, 2, 3, 4}; path_len = 5; end
            K_SW:                 begin path = '{0, 1, 2, 3, 0}; path_len = 4; end
            K_BEQ, K_BNE, K_J:    begin path = '{0, 1, 2, 0, 0}; path_len = 3; end
            default:              begin path = '{0, 1, 7, 0, 0}; path_len = 3; end
          endcase
        end
        if (mdl_idx == path_len - 1) begin
          mdl_cnt   = (mdl_cnt + 1) % (1 << RW);
          mdl_idx   = 0;
          mdl_phase = 0;
        end else begin
          mdl_idx++;
          mdl_phase = path[mdl_idx];
          if (mdl_phase == 7) mdl_illegal = 1'b1;
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] cur_op, cur_fn, o, f;
    bit r;
    int k, err_cycles;
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    cur_op = 6'h00; cur_fn = 6'h20; err_cycles = 0;

    applyStimulus(1, 6'h00, 6'h00, 0, 1);

    // add: 0,1,2,4 with junk opcode after ID
    applyStimulus(0, 6'h00, 6'h20, 0, 1);
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset mem_read", 32'(mem_read), 32'd1);
    checkOutput("reset cnt", 32'(retire_cnt), 32'd0);
    applyStimulus(0, 6'h00, 6'h20, 0, 1);
    checkOutput("add ID state", 32'(state), 32'd1);
    applyStimulus(0, 6'h3F, 6'h22, 0, 1);
    checkOutput("add EX state", 32'(state), 32'd2);
    checkOutput("add EX alu_op", 32'(alu_op), 32'd0);
    applyStimulus(0, 6'h3F, 6'h22, 0, 1);
    checkOutput("add WB state", 32'(state), 32'd4);
    checkOutput("add WB reg_write/reg_dst", 32'({reg_write, reg_dst}), 32'd3);

    // lw with two MEM wait cycles
    applyStimulus(0, 6'h23, 6'h00, 0, 1);
    checkOutput("lw IF state", 32'(state), 32'd0);
    checkOutput("add retired cnt", 32'(retire_cnt), 32'd1);
    applyStimulus(0, 6'h23, 6'h00, 0, 1);
    applyStimulus(0, 6'h00, 6'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 6'h00, 6'h00, 0, i == 2);
      checkOutput("lw MEM state", 32'(state), 32'd3);
      checkOutput("lw MEM mem_read", 32'(mem_read), 32'd1);
    end
    applyStimulus(0, 6'h00, 6'h00, 0, 1);
    checkOutput("lw WB mem_to_reg", 32'({state, mem_to_reg}), 32'({3'd4, 1'b1}));

    // beq then bne, both with zero=1
    applyStimulus(0, 6'h04, 6'h00, 1, 1);
    checkOutput("lw retired cnt", 32'(retire_cnt), 32'd2);
    applyStimulus(0, 6'h04, 6'h00, 1, 1);
    applyStimulus(0, 6'h05, 6'h00, 1, 1);
    checkOutput("beq EX pc_en/alu_op", 32'({pc_en, alu_op}), 32'b1001);
    applyStimulus(0, 6'h05, 6'h00, 1, 1);
    applyStimulus(0, 6'h05, 6'h00, 1, 1);
    applyStimulus(0, 6'h04, 6'h00, 1, 1);
    checkOutput("bne EX pc_en/alu_op", 32'({pc_en, alu_op}), 32'b0001);

    // sw interrupted by reset in MEM
    applyStimulus(0, 6'h2B, 6'h00, 0, 1);
    checkOutput("branches retired cnt", 32'(retire_cnt), 32'd4);
    applyStimulus(0, 6'h2B, 6'h00, 0, 1);
    applyStimulus(0, 6'h00, 6'h00, 0, 1);
    applyStimulus(1, 6'h00, 6'h00, 0, 0);
    checkOutput("sw MEM mem_write", 32'({state, mem_write}), 32'({3'd3, 1'b1}));
    applyStimulus(0, 6'h3F, 6'h00, 0, 1);
    checkOutput("sw reset state/mem_write/cnt", 32'({state, mem_write, retire_cnt}),
                32'({3'd0, 1'b0, 4'd0}));

    // illegal opcode traps until reset
    applyStimulus(0, 6'h3F, 6'h00, 0, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 6'h00, 6'h20, 1, 1);
      checkOutput("ERR state/illegal", 32'({state, illegal}), 32'({3'd7, 1'b1}));
      checkOutput("ERR strobes", 32'({ir_write, pc_en, reg_write, mem_read, mem_write, retire}),
                  32'd0);
    end
    applyStimulus(1, 6'h00, 6'h20, 0, 1);
    applyStimulus(0, 6'h02, 6'h00, 0, 1);
    checkOutput("ERR reset state/illegal", 32'({state, illegal}), 32'd0);

    // 16 jumps wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      if (i != 0) applyStimulus(0, 6'h02, 6'h00, 0, 1);
      if (i == 15) checkOutput("cnt before wrap", 32'(retire_cnt), 32'd15);
      applyStimulus(0, 6'h02, 6'h00, 0, 1);
      applyStimulus(0, 6'h3F, 6'h00, 0, 1);
      checkOutput("j EX pc_en/pc_source", 32'({pc_en, pc_source}), 32'b110);
    end
    applyStimulus(0, 6'h00, 6'h20, 0, 1);
    checkOutput("cnt wrapped", 32'(retire_cnt), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      #2;
      if (mdl_phase == 7) err_cycles++; else err_cycles = 0;
      r = (err_cycles >= 4) || ($urandom_range(0, 299) == 0);
      if (mdl_phase == 0) begin
        k = $urandom_range(0, 17);
        cur_fn = 6'($urandom);
        case (k % 9)
          0: begin cur_op = 6'h00; cur_fn = 6'h20; end
          1: begin cur_op = 6'h00; cur_fn = 6'h22; end
          2: cur_op = 6'h08;
          3: cur_op = 6'h23;
          4: cur_op = 6'h2B;
          5: cur_op = 6'h04;
          6: cur_op = 6'h05;
          7: cur_op = 6'h02;
          default: cur_op = 6'($urandom);
        endcase
      end
      if (mdl_phase == 0 || mdl_phase == 1) begin
        o = cur_op; f = cur_fn;
      end else begin
        o = 6'($urandom); f = 6'($urandom);
      end
      applyStimulus(r, o, f, bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    applyStimulus(0, 6'h00, 6'h00, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, meaning width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0].
REQ-006 SHALL have port zero  input  1  ALU Zero flag, same-cycle combinational.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have outputs ir_write, pc_en, reg_write, mem_read, mem_write, reg_dst, mem_to_reg, alu_src_a, each 1 bit, as datapath enables and selects.
REQ-009 SHALL have outputs alu_src_b  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and pc_source  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 SHALL have output alu_op  3  with 000 = add and 001 = subtract; no other value is ever driven.
REQ-011 SHALL have outputs state  3  (current state), illegal  1  (sticky error), retire  1  (one-cycle pulse) and retire_cnt  RETIRE_W.

Function
REQ-012 SHALL implement the states IF=0, ID=1, EX=2, MEM=3, WB=4 and ERR=7; encodings 5 and 6 SHALL go to ERR.
REQ-013 SHALL decode: R-type opcode 00 with funct 20h (add) or 22h (sub), addi 08h, lw 23h, sw 2Bh, beq 04h, bne 05h, j 02h; everything else is illegal.
REQ-014 IF: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; SHALL hold while mem_ready=0; when mem_ready=1, ir_write=1 and pc_en=1 in that cycle, then go to ID.
REQ-015 ID: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut); illegal opcode/funct goes to ERR, otherwise to EX.
REQ-016 EX for R-type: alu_src_a=1, alu_src_b=00, alu_op=000 for add and 001 for sub; next state WB.
REQ-017 EX for addi, lw, sw: alu_src_a=1, alu_src_b=10, alu_op=000; addi goes to WB, lw and sw go to MEM.
REQ-018 EX for beq/bne: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01; pc_en = zero for beq and ~zero for bne; next state IF, retire=1.
REQ-019 EX for j: pc_source=10, pc_en=1; next state IF, retire=1.
REQ-020 MEM: mem_read=1 for lw, mem_write=1 for sw; SHALL hold while mem_ready=0, with the strobes held steady. On mem_ready=1, lw goes to WB; sw goes to IF with retire=1.
REQ-021 WB: reg_write=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only; next state IF, retire=1.
REQ-022 Every output not listed for a state SHALL be 0; all outputs are Moore, except pc_en in EX (depends on zero) and the mem_ready-qualified strobes.
REQ-023 Latency SHALL be, with mem_ready tied 1: R-type/addi 4 cycles, lw 5, sw 4, beq/bne/j 3; each mem_ready=0 cycle adds one.
REQ-024 opcode and funct SHALL be sampled in ID and held in internal registers through instruction completion; changes on those inputs after ID have no effect.
REQ-025 ERR SHALL drive every strobe to 0, set illegal=1, and hold until rst.
REQ-026 retire_cnt SHALL increment by 1 on each retire pulse and wrap from all-ones to 0.

Reset
REQ-027 On rst=1 at a clock edge: state=IF, illegal=0, retire_cnt=0, latched opcode/funct=0; rst SHALL override any state, including mid-MEM and ERR.
REQ-028 In the first cycle after reset release, outputs SHALL be the IF values from REQ-014.

Structure
REQ-029 Package cpu_ctrl_pkg SHALL hold the opcode and funct constants, the state encodings, the alu_op codes (ADD=000, SUB=001) and the alu_src_b / pc_source select codes.
REQ-030 Sub-module mc_ctrl_decode (combinational: opcode, funct to instruction class and illegal) SHALL be instantiated once; the FSM and counters live in mc_control_fsm.

Verification
REQ-031 add (opcode 00, funct 20h), mem_ready=1: states 0,1,2,4,0; alu_op=000 in EX; reg_write=1 and reg_dst=1 in WB; retire_cnt 0 to 1.
REQ-032 lw (23h), mem_ready low 2 cycles in MEM: MEM lasts 3 cycles with mem_read=1 throughout; WB has mem_to_reg=1; total 7 cycles.
REQ-033 beq with zero=1, then bne with zero=1: pc_en=1 in the beq EX cycle and pc_en=0 in the bne EX cycle; alu_op=001 in both.
REQ-034 Opcode 3Fh: ID goes to ERR, illegal=1 and all strobes 0 for 10 cycles; rst=1 returns state to 0 and illegal to 0.
REQ-035 rst asserted mid-MEM of sw: next cycle state=IF, mem_write=0, retire_cnt=0.
REQ-036 retire_cnt preset via 2^RETIRE_W-1 retires (or RETIRE_W=4 with 16 j instructions): wraps to 0.
